// File: rtl/systolic_seq.sv
// systolic_seq: job sequencer for an N x N accumulate-and-shift PE grid.
//
// Reads one operand row/column pair per cycle from banked operand memories,
// applies the diagonal skew, and emits per-lane init pulses. Each init closes
// the running accumulation tile and starts the next one. Drained results
// from the bottom PE of each column go to that column's result memory.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 job request (sampled in IDLE only)
//   k_len, num_tiles      beats per tile, tiles per job (latched on start)
//   busy, done            job in flight / one-cycle completion pulse
//   rd_en, rd_addr        operand memory read strobe and shared address
//   mem_a_data/mem_b_data operand lanes, RD_LAT cycles after rd_en
//   a_out, b_out          skewed operands to the grid row/column inputs
//   init_out              skewed init per lane
//   res_valid, res_data   drain chain outputs from each grid column
//   res_wr_en/addr/data   per-column result memory write port
//
// Optional feature, enabled by defining SYSTOLIC_SEQ_PERF_EN:
//   cycle_cnt   busy-cycle counter, cleared on accepted start
//   stall_flag  sticky; set if results arrive in FEED before beat 2*N
module systolic_seq #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int N       = 4,
    parameter int K_MAX   = 16,
    parameter int T_MAX   = 8,
    parameter int RD_LAT  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(K_MAX+1)-1:0]          k_len,
    input  logic [$clog2(T_MAX+1)-1:0]          num_tiles,
    output logic                                busy,
    output logic                                done,
    output logic                                rd_en,
    output logic [$clog2(K_MAX*T_MAX)-1:0]      rd_addr,
    input  logic [N*D_W-1:0]                    mem_a_data,
    input  logic [N*D_W-1:0]                    mem_b_data,
    output logic [N*D_W-1:0]                    a_out,
    output logic [N*D_W-1:0]                    b_out,
    output logic [N-1:0]                        init_out,
    input  logic [N-1:0]                        res_valid,
    input  logic [N*D_W_ACC-1:0]                res_data,
`ifdef SYSTOLIC_SEQ_PERF_EN
    output logic [31:0]                         cycle_cnt,
    output logic                                stall_flag,
`endif
    output logic [N-1:0]                        res_wr_en,
    output logic [N*$clog2(T_MAX*N)-1:0]        res_wr_addr,
    output logic [N*D_W_ACC-1:0]                res_wr_data
);

    localparam int KW  = $clog2(K_MAX + 1);
    localparam int TW  = $clog2(T_MAX + 1);
    localparam int AW  = $clog2(K_MAX * T_MAX);
    localparam int RAW = $clog2(T_MAX * N);
    localparam int PW  = KW + TW;
    // Per column: N discarded dump beats plus num_tiles*N real results.
    localparam int CW  = $clog2(N * (T_MAX + 1) + 1);

    typedef enum logic [2:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [KW-1:0]     r_k;
    logic [AW-1:0]     r_last;
    logic [CW-1:0]     r_target;
    logic [KW-1:0]     r_beat;
    logic [AW-1:0]     r_rd_addr;
    logic              r_rd_en;
    logic              r_busy;
    logic              r_done;
    logic [RD_LAT-1:0] r_pipe_init;
    logic [RD_LAT-1:0] r_pipe_feed;

    logic              w_accept;
    logic              w_zero_job;
    logic [PW-1:0]     w_prod;
    logic [CW-1:0]     w_target;
    logic              w_beat_last;
    logic              w_addr_last;
    logic              w_init_base;
    logic              w_feed;
    logic [N-1:0]      w_col_done;
    logic              w_all_drained;
    logic [N*D_W-1:0]  w_a;
    logic [N*D_W-1:0]  w_b;
    logic              w_init_al;

    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_zero_job    = (k_len == {KW{1'b0}}) || (num_tiles == {TW{1'b0}});
    assign w_prod        = {{TW{1'b0}}, k_len} * {{KW{1'b0}}, num_tiles};
    assign w_target      = CW'(({{(CW-TW){1'b0}}, num_tiles} + CW'(1)) * CW'(N));
    assign w_beat_last   = (r_beat == (r_k - {{(KW-1){1'b0}}, 1'b1}));
    assign w_addr_last   = (r_rd_addr == r_last);
    assign w_feed        = (r_state == S_FEED);
    assign w_init_base   = ((r_state == S_FEED) || (r_state == S_FLUSH)) &&
                           (r_beat == {KW{1'b0}});
    assign w_all_drained = &w_col_done;

    // Operands are forced to zero unless the aligned beat was a real read.
    assign w_a       = r_pipe_feed[RD_LAT-1] ? mem_a_data : {(N*D_W){1'b0}};
    assign w_b       = r_pipe_feed[RD_LAT-1] ? mem_b_data : {(N*D_W){1'b0}};
    assign w_init_al = r_pipe_init[RD_LAT-1];

    assign busy    = r_busy;
    assign done    = r_done;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;

    // Next-state decode for the job FSM.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nx = w_zero_job ? S_DONE : S_FEED;
                else       w_state_nx = S_IDLE;
            end
            S_FEED: begin
                if (w_addr_last) w_state_nx = S_FLUSH;
                else             w_state_nx = S_FEED;
            end
            S_FLUSH: begin
                if (w_beat_last) w_state_nx = S_DRAIN;
                else             w_state_nx = S_FLUSH;
            end
            S_DRAIN: begin
                if (w_all_drained) w_state_nx = S_DONE;
                else               w_state_nx = S_DRAIN;
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // State register, job parameters and status outputs decoded from next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_k      <= {KW{1'b0}};
            r_last   <= {AW{1'b0}};
            r_target <= {CW{1'b0}};
            r_rd_en  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_rd_en <= (w_state_nx == S_FEED);
            r_busy  <= (w_state_nx == S_FEED) || (w_state_nx == S_FLUSH) ||
                       (w_state_nx == S_DRAIN);
            r_done  <= (w_state_nx == S_DONE);
            if (w_accept) begin
                r_k      <= k_len;
                r_last   <= AW'(w_prod - {{(PW-1){1'b0}}, 1'b1});
                r_target <= w_target;
            end
        end
    end

    // Read address and beat-within-tile counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat    <= {KW{1'b0}};
            r_rd_addr <= {AW{1'b0}};
        end else begin
            case (r_state)
                S_FEED: begin
                    if (w_addr_last) begin
                        r_beat    <= {KW{1'b0}};
                        r_rd_addr <= {AW{1'b0}};
                    end else begin
                        r_rd_addr <= r_rd_addr + {{(AW-1){1'b0}}, 1'b1};
                        r_beat    <= w_beat_last ? {KW{1'b0}}
                                                 : r_beat + {{(KW-1){1'b0}}, 1'b1};
                    end
                end
                S_FLUSH: begin
                    r_beat <= w_beat_last ? {KW{1'b0}}
                                          : r_beat + {{(KW-1){1'b0}}, 1'b1};
                end
                default: begin
                    r_beat    <= {KW{1'b0}};
                    r_rd_addr <= {AW{1'b0}};
                end
            endcase
        end
    end

    // Carries init and the real-read flag alongside the memory read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_init <= {RD_LAT{1'b0}};
            r_pipe_feed <= {RD_LAT{1'b0}};
        end else begin
            r_pipe_init[0] <= w_init_base;
            r_pipe_feed[0] <= w_feed;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_init[i] <= r_pipe_init[i-1];
                r_pipe_feed[i] <= r_pipe_feed[i-1];
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        // Stage 0 is the output register; lane g adds g more stages of skew.
        logic [D_W-1:0] r_sk_a [0:g];
        logic [D_W-1:0] r_sk_b [0:g];
        logic           r_sk_i [0:g];

        // Diagonal skew delay line for lane g.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j <= g; j++) begin
                    r_sk_a[j] <= {D_W{1'b0}};
                    r_sk_b[j] <= {D_W{1'b0}};
                    r_sk_i[j] <= 1'b0;
                end
            end else begin
                r_sk_a[0] <= w_a[g*D_W +: D_W];
                r_sk_b[0] <= w_b[g*D_W +: D_W];
                r_sk_i[0] <= w_init_al;
                for (int j = 1; j <= g; j++) begin
                    r_sk_a[j] <= r_sk_a[j-1];
                    r_sk_b[j] <= r_sk_b[j-1];
                    r_sk_i[j] <= r_sk_i[j-1];
                end
            end
        end

        assign a_out[g*D_W +: D_W] = r_sk_a[g];
        assign b_out[g*D_W +: D_W] = r_sk_b[g];
        assign init_out[g]         = r_sk_i[g];

        logic [CW-1:0]      r_col_cnt;
        logic               r_wr_en;
        logic [RAW-1:0]     r_wr_addr;
        logic [D_W_ACC-1:0] r_wr_data;

        // Column result collection; the first N beats are the dump of the
        // never-initialised accumulators and are dropped.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_col_cnt <= {CW{1'b0}};
                r_wr_en   <= 1'b0;
                r_wr_addr <= {RAW{1'b0}};
                r_wr_data <= {D_W_ACC{1'b0}};
            end else begin
                if (w_accept)          r_col_cnt <= {CW{1'b0}};
                else if (res_valid[g]) r_col_cnt <= r_col_cnt + {{(CW-1){1'b0}}, 1'b1};
                r_wr_en   <= res_valid[g] && (r_col_cnt >= CW'(N));
                r_wr_addr <= RAW'(r_col_cnt - CW'(N));
                if (res_valid[g]) r_wr_data <= res_data[g*D_W_ACC +: D_W_ACC];
            end
        end

        assign w_col_done[g]                      = (r_col_cnt == r_target);
        assign res_wr_en[g]                       = r_wr_en;
        assign res_wr_addr[g*RAW +: RAW]          = r_wr_addr;
        assign res_wr_data[g*D_W_ACC +: D_W_ACC]  = r_wr_data;
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic        r_stall;

    // Busy-cycle counter and early-result stall detector.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= 32'd0;
            r_stall     <= 1'b0;
        end else if (w_accept) begin
            r_cycle_cnt <= 32'd0;
            r_stall     <= 1'b0;
        end else begin
            if (r_busy) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_feed && (|res_valid) && (r_rd_addr < AW'(2 * N))) r_stall <= 1'b1;
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign stall_flag = r_stall;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
`timescale 1ns/1ps
module tb_systolic_seq;

    localparam int D_W = 8, D_W_ACC = 16, N = 4, K_MAX = 16, T_MAX = 8, RD_LAT = 1;
    localparam int KW  = $clog2(K_MAX + 1);
    localparam int TW  = $clog2(T_MAX + 1);
    localparam int AW  = $clog2(K_MAX * T_MAX);
    localparam int RAW = $clog2(T_MAX * N);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [KW-1:0]        k_len = '0;
    logic [TW-1:0]        num_tiles = '0;
    logic                 busy, done, rd_en;
    logic [AW-1:0]        rd_addr;
    logic [N*D_W-1:0]     mem_a_data = '0;
    logic [N*D_W-1:0]     mem_b_data = '0;
    logic [N*D_W-1:0]     a_out, b_out;
    logic [N-1:0]         init_out;
    logic [N-1:0]         res_valid = '0;
    logic [N*D_W_ACC-1:0] res_data = '0;
    logic [N-1:0]         res_wr_en;
    logic [N*RAW-1:0]     res_wr_addr;
    logic [N*D_W_ACC-1:0] res_wr_data;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0]          cycle_cnt;
    logic                 stall_flag;
`endif

    systolic_seq #(.D_W(D_W), .D_W_ACC(D_W_ACC), .N(N), .K_MAX(K_MAX),
                   .T_MAX(T_MAX), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .num_tiles(num_tiles),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .mem_a_data(mem_a_data), .mem_b_data(mem_b_data),
        .a_out(a_out), .b_out(b_out), .init_out(init_out),
        .res_valid(res_valid), .res_data(res_data),
`ifdef SYSTOLIC_SEQ_PERF_EN
        .cycle_cnt(cycle_cnt), .stall_flag(stall_flag),
`endif
        .res_wr_en(res_wr_en), .res_wr_addr(res_wr_addr), .res_wr_data(res_wr_data)
    );

    always #5 clk = ~clk;

    // Operand memory model: one-cycle read latency, A lanes all 1, B lanes all 2.
    always @(posedge clk) begin
        if (rd_en) begin
            mem_a_data <= {N{8'd1}};
            mem_b_data <= {N{8'd2}};
        end
    end

    int passes = 0, fails = 0, total = 0;
    int cyc = 0, t_start = 0;
    int rd_cnt, done_cnt, done_cyc, busy_done_bad, busy_cnt;
    int init0_cnt, init3_cnt, init0_first, init3_first;
    int a0_first, a3_first, a0_nz, b0_val;
    int rd_log [256];
    int wr_cnt [N];
    int wr_addr_log [N][64];
    int wr_data_log [N][64];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        rd_cnt = 0; done_cnt = 0; done_cyc = -1; busy_done_bad = 0; busy_cnt = 0;
        init0_cnt = 0; init3_cnt = 0; init0_first = -1; init3_first = -1;
        a0_first = -1; a3_first = -1; a0_nz = 0; b0_val = -1;
        for (int c = 0; c < N; c++) wr_cnt[c] = 0;
    endtask

    // Advance one cycle and sample every DUT output on the falling edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rd_en) begin
            if (rd_cnt < 256) rd_log[rd_cnt] = int'(rd_addr);
            rd_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) busy_done_bad++;
        end
        if (busy) busy_cnt++;
        if (init_out[0]) begin
            init0_cnt++;
            if (init0_first < 0) init0_first = cyc;
        end
        if (init_out[3]) begin
            init3_cnt++;
            if (init3_first < 0) init3_first = cyc;
        end
        if (a_out[0 +: D_W] != 8'd0) begin
            a0_nz++;
            if (a0_first < 0) a0_first = cyc;
        end
        if (a_out[3*D_W +: D_W] != 8'd0 && a3_first < 0) a3_first = cyc;
        if (b_out[0 +: D_W] != 8'd0 && b0_val < 0) b0_val = int'(b_out[0 +: D_W]);
        for (int c = 0; c < N; c++) begin
            if (res_wr_en[c]) begin
                if (wr_cnt[c] < 64) begin
                    wr_addr_log[c][wr_cnt[c]] = int'(res_wr_addr[c*RAW +: RAW]);
                    wr_data_log[c][wr_cnt[c]] = int'(res_wr_data[c*D_W_ACC +: D_W_ACC]);
                end
                wr_cnt[c]++;
            end
        end
    endtask

    task automatic start_job(input int k, input int t);
        k_len = KW'(k);
        num_tiles = TW'(t);
        start = 1'b1;
        t_start = cyc;
        tick();
        start = 1'b0;
    endtask

    // Drive beats on all columns; const_mode gives N dump beats then value 4.
    task automatic inject(input int beats, input bit const_mode);
        for (int j = 0; j < beats; j++) begin
            res_valid = '1;
            for (int c = 0; c < N; c++) begin
                if (const_mode) res_data[c*D_W_ACC +: D_W_ACC] = (j < N) ? 16'h00EE : 16'd4;
                else            res_data[c*D_W_ACC +: D_W_ACC] = 16'(j * 16 + c);
            end
            tick();
        end
        res_valid = '0;
        res_data = '0;
    endtask

    task automatic wait_done(input int limit);
        int n = 0;
        while (done_cnt == 0 && n < limit) begin
            tick();
            n++;
        end
        check("done_seen", done_cnt, 1);
    endtask

    task automatic check_const_writes(input string tag);
        for (int c = 0; c < N; c++) begin
            check({tag, "_wr_cnt"}, wr_cnt[c], 4);
            for (int n = 0; n < 4; n++) begin
                check({tag, "_wr_addr"}, wr_addr_log[c][n], n);
                check({tag, "_wr_data"}, wr_data_log[c][n], 4);
            end
        end
    endtask

    initial begin
        clear_logs();
        // Reset state
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_a_out", a_out, 0);
        check("rst_init_out", init_out, 0);
        check("rst_wr_en", res_wr_en, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Job 1: k_len=2, num_tiles=1
        clear_logs();
        start_job(2, 1);
        repeat (10) tick();
        inject(8, 1'b1);
        wait_done(50);
        check("j1_busy_with_done", busy_done_bad, 0);
`ifdef SYSTOLIC_SEQ_PERF_EN
        check("j1_cycle_cnt", cycle_cnt, busy_cnt);
        check("j1_stall", stall_flag, 0);
`endif
        repeat (5) tick();
`ifdef SYSTOLIC_SEQ_PERF_EN
        check("j1_cycle_cnt_held", cycle_cnt, busy_cnt);
`endif
        check("j1_done_once", done_cnt, 1);
        check("j1_rd_cnt", rd_cnt, 2);
        check("j1_rd_addr0", rd_log[0], 0);
        check("j1_rd_addr1", rd_log[1], 1);
        check("j1_a0_latency", a0_first - t_start, 2 + RD_LAT);
        check("j1_a3_skew", a3_first - a0_first, 3);
        check("j1_a0_beats", a0_nz, 2);
        check("j1_b0_value", b0_val, 2);
        check("j1_init0_pulses", init0_cnt, 2);
        check("j1_init3_pulses", init3_cnt, 2);
        check("j1_init_skew", init3_first - init0_first, 3);
        check("j1_init0_latency", init0_first - t_start, 2 + RD_LAT);
        check_const_writes("j1");

        // Job 2: num_tiles=0, then k_len=0
        clear_logs();
        start_job(2, 0);
        repeat (4) tick();
        check("j2_done_cyc", done_cyc - t_start, 1);
        check("j2_done_once", done_cnt, 1);
        check("j2_rd_cnt", rd_cnt, 0);
        check("j2_busy_cnt", busy_cnt, 0);
        check("j2_writes", wr_cnt[0] + wr_cnt[1] + wr_cnt[2] + wr_cnt[3], 0);
        clear_logs();
        start_job(0, 3);
        repeat (4) tick();
        check("j2b_done_cyc", done_cyc - t_start, 1);
        check("j2b_rd_cnt", rd_cnt, 0);

        // Job 3: k_len=3, num_tiles=2 with a second start during FEED
        clear_logs();
        start_job(3, 2);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        inject(12, 1'b0);
        wait_done(50);
        repeat (5) tick();
        check("j3_done_once", done_cnt, 1);
        check("j3_rd_cnt", rd_cnt, 6);
        for (int i = 0; i < 6; i++) check("j3_rd_addr", rd_log[i], i);
        check("j3_init0_pulses", init0_cnt, 3);
        for (int c = 0; c < N; c++) begin
            check("j3_wr_cnt", wr_cnt[c], 8);
            for (int n = 0; n < 8; n++) begin
                check("j3_wr_addr", wr_addr_log[c][n], n);
                check("j3_wr_data", wr_data_log[c][n], (n + N) * 16 + c);
            end
        end

        // Job 4: reset at FEED beat 1, then a clean job
        clear_logs();
        start_job(4, 2);
        tick();
        check("j4_pre_rst_addr", rd_addr, 1);
        rst = 1'b1;
        tick();
        check("j4_rst_busy", busy, 0);
        check("j4_rst_done", done, 0);
        check("j4_rst_rd_en", rd_en, 0);
        check("j4_rst_rd_addr", rd_addr, 0);
        check("j4_rst_a_out", a_out, 0);
        check("j4_rst_b_out", b_out, 0);
        check("j4_rst_init", init_out, 0);
        check("j4_rst_wr_en", res_wr_en, 0);
        check("j4_rst_wr_addr", res_wr_addr, 0);
        check("j4_rst_wr_data", res_wr_data, 0);
        rst = 1'b0;
        repeat (20) tick();
        check("j4_no_done", done_cnt, 0);
        check("j4_rd_cnt", rd_cnt, 2);
        clear_logs();
        start_job(2, 1);
        repeat (10) tick();
        inject(8, 1'b1);
        wait_done(50);
        repeat (3) tick();
        check("j4b_done_once", done_cnt, 1);
        check("j4b_rd_cnt", rd_cnt, 2);
        check_const_writes("j4b");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
